// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types and constants for the MEM/WB skid stage.
//   state_t          stage occupancy state (EMPTY / BUSY / FULL)
//   DATA_W/RW_W/CTRL_W  default payload widths
//   CTRL_REGWR/CTRL_MEMTOREG  bit positions inside the writeback control vector
//   mem_wb_payload_t default-width view of one stage entry
//   occupancy_of()   maps a state to its entry count
package mem_wb_pkg;

   localparam int DATA_W = 32;
   localparam int RW_W   = 5;
   localparam int CTRL_W = 2;

   localparam int CTRL_REGWR    = 0;
   localparam int CTRL_MEMTOREG = 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] memory;
      logic [DATA_W-1:0] result;
      logic [RW_W-1:0]   rw;
      logic [CTRL_W-1:0] ctrl;
   } mem_wb_payload_t;

   function automatic logic [1:0] occupancy_of(input state_t s);
      case (s)
         BUSY:    return 2'd1;
         FULL:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_wb_skid_stage_sat_counter.sv
// sat_counter: saturating up-counter, updated on the falling clock edge.
//   clk  clock (falling edge active)
//   rst  asynchronous active-low reset
//   inc  add one, holding at all-ones
//   clr  synchronous clear, wins over inc
//   cnt  current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] r_cnt;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the values from before the edge.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + ONE;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM/WB pipeline register with a valid/ready handshake and
// a 2-entry skid buffer. All state changes on the falling clock edge.
//   clk, rst          clock (falling edge) and async active-low reset
//   flush             synchronous kill of every held entry
//   clr_stats         synchronous clear of stall_cnt
//   in_valid/in_ready MEM-side handshake; in_ready depends on state only
//   memory_in, result_in, Rw_in, ctrl_in   incoming payload
//   out_valid/out_ready WB-side handshake
//   memory_out, result_out, Rw_out, ctrl_out  payload of the oldest entry
//   occupancy         entries held (0..2)
//   stall_cnt         saturating count of edges with out_valid & !out_ready
module mem_wb_skid_stage #(
   parameter int DATA_W  = mem_wb_pkg::DATA_W,
   parameter int RW_W    = mem_wb_pkg::RW_W,
   parameter int CTRL_W  = mem_wb_pkg::CTRL_W,
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               clr_stats,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  memory_in,
   input  logic [DATA_W-1:0]  result_in,
   input  logic [RW_W-1:0]    Rw_in,
   input  logic [CTRL_W-1:0]  ctrl_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  memory_out,
   output logic [DATA_W-1:0]  result_out,
   output logic [RW_W-1:0]    Rw_out,
   output logic [CTRL_W-1:0]  ctrl_out,
   output logic [1:0]         occupancy,
   output logic [STALL_W-1:0] stall_cnt
);

   import mem_wb_pkg::state_t;
   import mem_wb_pkg::EMPTY;
   import mem_wb_pkg::BUSY;
   import mem_wb_pkg::FULL;
   import mem_wb_pkg::occupancy_of;

   // Parametrised payload; the package struct is the default-width view.
   typedef struct packed {
      logic [DATA_W-1:0] memory;
      logic [DATA_W-1:0] result;
      logic [RW_W-1:0]   rw;
      logic [CTRL_W-1:0] ctrl;
   } payload_t;

   state_t   r_state, w_state_nxt;
   payload_t r_main, w_main_nxt;
   payload_t r_skid, w_skid_nxt;
   payload_t w_in;
   logic     w_accept, w_consume;

   assign w_in      = {memory_in, result_in, Rw_in, ctrl_in};
   assign in_ready  = (r_state != FULL) && rst;
   assign out_valid = (r_state != EMPTY);
   assign w_accept  = in_valid && in_ready;
   assign w_consume = out_valid && out_ready;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (flush) begin
         // A consume this cycle still happens on the WB side; only what is
         // left afterwards is killed, and the incoming entry is dropped.
         w_state_nxt = EMPTY;
         w_main_nxt  = '0;
         w_skid_nxt  = '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_main_nxt  = w_in;
                  w_state_nxt = BUSY;
               end
            end
            BUSY: begin
               if (w_accept && w_consume) begin
                  w_main_nxt = w_in;
               end else if (w_accept) begin
                  w_skid_nxt  = w_in;
                  w_state_nxt = FULL;
               end else if (w_consume) begin
                  // Clearing main keeps bubbles at zero, so RegWr is never set.
                  w_main_nxt  = '0;
                  w_state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (w_consume) begin
                  w_main_nxt  = r_skid;
                  w_skid_nxt  = '0;
                  w_state_nxt = BUSY;
               end
            end
            default: begin
               w_state_nxt = EMPTY;
               w_main_nxt  = '0;
               w_skid_nxt  = '0;
            end
         endcase
      end
   end

   // NOTE: the payload registers are reset along with the state because the
   // outputs are driven straight from main and must read zero after reset.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   assign memory_out = r_main.memory;
   assign result_out = r_main.result;
   assign Rw_out     = r_main.rw;
   assign ctrl_out   = r_main.ctrl;
   assign occupancy  = occupancy_of(r_state);

   sat_counter #(
      .W (STALL_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (out_valid && !out_ready),
      .clr (clr_stats),
      .cnt (stall_cnt)
   );

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage built with DATA_W=64, RW_W=6, STALL_W=4.
// Inputs change 1 time unit after each falling edge; outputs are checked there.
module tb_mem_wb_skid_stage;

   import mem_wb_pkg::CTRL_REGWR;
   import mem_wb_pkg::CTRL_MEMTOREG;

   localparam int DW = 64;
   localparam int RW = 6;
   localparam int CW = 2;
   localparam int SW = 4;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          clr_stats;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] memory_in;
   logic [DW-1:0] result_in;
   logic [RW-1:0] Rw_in;
   logic [CW-1:0] ctrl_in;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] memory_out;
   logic [DW-1:0] result_out;
   logic [RW-1:0] Rw_out;
   logic [CW-1:0] ctrl_out;
   logic [1:0]    occupancy;
   logic [SW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   mem_wb_skid_stage #(
      .DATA_W  (DW),
      .RW_W    (RW),
      .CTRL_W  (CW),
      .STALL_W (SW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .clr_stats  (clr_stats),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .memory_in  (memory_in),
      .result_in  (result_in),
      .Rw_in      (Rw_in),
      .ctrl_in    (ctrl_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .memory_out (memory_out),
      .result_out (result_out),
      .Rw_out     (Rw_out),
      .ctrl_out   (ctrl_out),
      .occupancy  (occupancy),
      .stall_cnt  (stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic edge_step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset_stream();
      rst = 1'b0; flush = 1'b0; clr_stats = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      memory_in = '0; result_in = '0; Rw_in = '0; ctrl_in = '0;
      repeat (3) edge_step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
      checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
      checks++; if ({memory_out, result_out, Rw_out, ctrl_out} !== '0) begin errors++; $display("FAIL reset_payload: got result %h ctrl %b want 0", result_out, ctrl_out); end
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         result_in = DW'(i);
         edge_step();
         checks++; if (result_out !== DW'(i)) begin errors++; $display("FAIL stream_result_%0d: got %h want %h", i, result_out, DW'(i)); end
         checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ_%0d: got %0d want 1", i, occupancy); end
      end
      in_valid = 1'b0;
      edge_step();
      checks++; if (out_valid !== 1'b0 || result_out !== '0) begin errors++; $display("FAIL stream_drain: got valid %b result %h want 0/0", out_valid, result_out); end
      checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stream_stall: got %0d want 0", stall_cnt); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; result_in = 64'hA;
      edge_step();
      checks++; if (occupancy !== 2'd1 || stall_cnt !== 4'd0) begin errors++; $display("FAIL bp_first: got occ %0d stall %0d want 1/0", occupancy, stall_cnt); end
      result_in = 64'hB;
      edge_step();
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_full_occ: got %0d want 2", occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
      checks++; if (result_out !== 64'hA) begin errors++; $display("FAIL bp_head: got %h want a", result_out); end
      checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL bp_stall_1: got %0d want 1", stall_cnt); end
      result_in = 64'hD;
      edge_step();
      checks++; if (stall_cnt !== 4'd2 || occupancy !== 2'd2) begin errors++; $display("FAIL bp_stall_2: got stall %0d occ %0d want 2/2", stall_cnt, occupancy); end
      in_valid = 1'b0; out_ready = 1'b1;
      edge_step();
      checks++; if (result_out !== 64'hB) begin errors++; $display("FAIL bp_second: got %h want b", result_out); end
      checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_ready_back: got ready %b occ %0d want 1/1", in_ready, occupancy); end
      checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL bp_stall_hold: got %0d want 2", stall_cnt); end
      edge_step();
      checks++; if (out_valid !== 1'b0 || result_out !== '0) begin errors++; $display("FAIL bp_empty: got valid %b result %h want 0/0", out_valid, result_out); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; ctrl_in = 2'b01; Rw_in = 6'd9;
      result_in = 64'h1;
      edge_step();
      result_in = 64'h2;
      edge_step();
      checks++; if (occupancy !== 2'd2 || ctrl_out !== 2'b01) begin errors++; $display("FAIL flush_setup: got occ %0d ctrl %b want 2/01", occupancy, ctrl_out); end
      flush = 1'b1; result_in = 64'hC;
      edge_step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_state: got valid %b occ %0d want 0/0", out_valid, occupancy); end
      checks++; if ({memory_out, result_out, Rw_out, ctrl_out} !== '0) begin errors++; $display("FAIL flush_payload: got result %h rw %0d ctrl %b want 0", result_out, Rw_out, ctrl_out); end
      checks++; if (ctrl_out[CTRL_REGWR] !== 1'b0 || ctrl_out[CTRL_MEMTOREG] !== 1'b0) begin errors++; $display("FAIL flush_regwr: got ctrl %b want 00", ctrl_out); end
      checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL flush_stall: got %0d want 4", stall_cnt); end
      edge_step();
      checks++; if (out_valid !== 1'b0 || result_out !== '0) begin errors++; $display("FAIL flush_dropped: got valid %b result %h want 0/0", out_valid, result_out); end
   endtask

   task automatic test_saturation();
      clr_stats = 1'b1; in_valid = 1'b1; result_in = 64'h5; ctrl_in = 2'b11;
      edge_step();
      clr_stats = 1'b0; in_valid = 1'b0;
      checks++; if (stall_cnt !== 4'd0 || occupancy !== 2'd1) begin errors++; $display("FAIL sat_clear: got stall %0d occ %0d want 0/1", stall_cnt, occupancy); end
      repeat (14) edge_step();
      checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d want 14", stall_cnt); end
      repeat (6) edge_step();
      checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
      clr_stats = 1'b1;
      edge_step();
      clr_stats = 1'b0;
      checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr: got %0d want 0", stall_cnt); end
      edge_step();
      checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL sat_restart: got %0d want 1", stall_cnt); end
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; result_in = 64'h6;
      edge_step();
      in_valid = 1'b0;
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL ar_full: got %0d want 2", occupancy); end
      #2 rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL ar_immediate: got valid %b occ %0d ready %b want 0/0/0", out_valid, occupancy, in_ready); end
      checks++; if (result_out !== '0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL ar_clear: got result %h stall %0d want 0/0", result_out, stall_cnt); end
      in_valid = 1'b1;
      repeat (2) edge_step();
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL ar_held: got valid %b occ %0d ready %b want 0/0/0", out_valid, occupancy, in_ready); end
      in_valid = 1'b0;
      rst = 1'b1;
      edge_step();
   endtask

   task automatic test_wide_payload();
      out_ready = 1'b1; in_valid = 1'b1;
      memory_in = 64'hFFFF_0000_1234_5678;
      result_in = 64'h8000_0000_0000_0001;
      Rw_in = 6'd63; ctrl_in = 2'b11;
      edge_step();
      in_valid = 1'b0;
      checks++; if (memory_out !== 64'hFFFF_0000_1234_5678) begin errors++; $display("FAIL wide_memory: got %h want ffff000012345678", memory_out); end
      checks++; if (result_out !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL wide_result: got %h want 8000000000000001", result_out); end
      checks++; if (Rw_out !== 6'd63 || ctrl_out !== 2'b11) begin errors++; $display("FAIL wide_rw_ctrl: got %0d/%b want 63/11", Rw_out, ctrl_out); end
      edge_step();
      checks++; if (out_valid !== 1'b0 || {memory_out, Rw_out, ctrl_out} !== '0) begin errors++; $display("FAIL wide_bubble: got valid %b mem %h rw %0d want 0", out_valid, memory_out, Rw_out); end
   endtask

   initial begin
      test_reset_stream();
      test_backpressure();
      test_flush();
      test_saturation();
      test_async_reset();
      test_wide_payload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
